gen_core_arbiter: RTL and testbench

//  Shares one generated generator core (__start/__ready/__done/__valid/__output_0 protocol) between N requesters.

---
 rtl/gen_arb_pkg.sv | 18 +
 rtl/gen_core_arbiter_rr_picker.sv | 29 ++
 rtl/gen_core_arbiter.sv | 122 ++++++++++++
 tb/tb_gen_core_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_arb_pkg.sv
// Shared types for the generator-core arbiter: FSM states, beat record and width helper.
package gen_arb_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, LAST} state_t;

  // Beat record sized for the widest configuration in use; narrower ports zero-extend into it.
  typedef struct packed {
    logic [7:0]         id;
    logic signed [63:0] data;
    logic               last;
    logic               err;
  } beat_t;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gen_core_arbiter_rr_picker.sv
// Round-robin selection: first asserted request strictly after the pointer, wrapping modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = ID_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gen_core_arbiter.sv
// Shares one generator core among N_REQ requesters, streaming tagged yields plus a closing beat,
// with a watchdog that resets a stalled core and closes the run with an error beat.
module gen_core_arbiter
  import gen_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_IDLE = 1024
) (
  input  logic                       __clock,
  input  logic                       __reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_arg,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       core_start,
  output logic signed [DATA_W-1:0]   core_arg,
  output logic                       core_reset,
  output logic                       core_ready,
  input  logic                       core_valid,
  input  logic signed [DATA_W-1:0]   core_output,
  input  logic                       core_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_last,
  output logic                       out_err
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(MAX_IDLE + 1);

  state_t                    state;
  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           id_q;
  logic signed [DATA_W-1:0]  arg_q;
  logic                      err_q;
  logic                      wd_q;
  logic [CNT_W-1:0]          idle_cnt;

  logic [N_REQ-1:0]          pick_grant;
  logic [ID_W-1:0]           pick_idx;
  logic                      pick_any;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge __clock) begin
    if (__reset) begin
      state    <= IDLE;
      ptr      <= ID_W'(N_REQ - 1);
      idle_cnt <= '0;
      err_q    <= 1'b0;
      wd_q     <= 1'b0;
    end else begin
      wd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            ptr   <= pick_idx;
            err_q <= 1'b0;
            state <= START;
          end
        end
        START: begin
          idle_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          // Backpressure stalls (out_ready low) are not the core's fault, so they do not count.
          if (core_done && out_ready) begin
            state <= LAST;
          end else if (core_valid || core_done) begin
            idle_cnt <= '0;
          end else if (out_ready) begin
            if (idle_cnt == CNT_W'(MAX_IDLE - 1)) begin
              wd_q  <= 1'b1;
              err_q <= 1'b1;
              state <= LAST;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        LAST: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Argument and owner are plain data latches captured at the grant.
  always_ff @(posedge __clock) begin
    if (state == IDLE && pick_any) begin
      arg_q <= req_arg[int'(pick_idx)*DATA_W +: DATA_W];
      id_q  <= pick_idx;
    end
  end

  always_comb begin
    req_ready  = (state == IDLE && !__reset) ? pick_grant : '0;
    core_start = (state == START);
    core_arg   = (state == START) ? arg_q : '0;
    core_reset = __reset | wd_q;
    core_ready = (state == RUN) & out_ready;
    out_valid  = ((state == RUN) & core_valid) | (state == LAST);
    out_id     = (state == RUN || state == LAST) ? id_q : '0;
    out_data   = (state == RUN) ? core_output : '0;
    out_last   = (state == LAST);
    out_err    = (state == LAST) & err_q;
  end

endmodule

// File: tb/tb_gen_core_arbiter.sv
// Randomised scoreboard bench: an even_fib core model is the shared resource, expected beats come from a reference model.
module tb_gen_core_arbiter;
  import gen_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MI = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N*DW-1:0]     req_arg = '0;
  logic [N-1:0]        req_ready;
  logic                core_start;
  logic signed [DW-1:0] core_arg;
  logic                core_reset;
  logic                core_ready;
  logic                core_valid;
  logic signed [DW-1:0] core_output;
  logic                core_done;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [1:0]          out_id;
  logic signed [DW-1:0] out_data;
  logic                out_last;
  logic                out_err;

  gen_core_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_IDLE(MI)) dut (
    .__clock(clk), .__reset(rst),
    .req_valid(req_valid), .req_arg(req_arg), .req_ready(req_ready),
    .core_start(core_start), .core_arg(core_arg), .core_reset(core_reset),
    .core_ready(core_ready), .core_valid(core_valid), .core_output(core_output),
    .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_data(out_data), .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int model_ptr = N - 1;
  beat_t sbq[$];
  int grant_log[$];
  int quota[N];
  logic [DW-1:0] arg_tab[N];
  logic [N-1:0] gnt_seen = '0;
  int grant_cyc = 0, start_cyc = 0, last_acc_cyc = -100, last_gap = 0;
  logic [DW-1:0] gnt_arg = '0;
  bit stub = 0;
  bit rand_req = 0;
  int ormode = 0;
  int wd_seen = 0;
  int beats_acc = 0;
  int vals_in_run = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: the core yields every odd Fibonacci number below its argument, then finishes.
  task automatic push_expected(input int id, input int arg, input bit is_stub);
    int a, b, t;
    beat_t e;
    a = 1; b = 1;
    if (!is_stub) begin
      while (a < arg) begin
        if (a % 2 == 1) begin
          e.id = 8'(id); e.data = 64'(a); e.last = 1'b0; e.err = 1'b0;
          sbq.push_back(e);
        end
        t = a + b; a = b; b = t;
      end
    end
    e.id = 8'(id); e.data = '0; e.last = 1'b1; e.err = is_stub;
    sbq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // even_fib core model: one Fibonacci step per cycle, even terms are silent, random bubbles.
  initial begin
    int fa, fb, t, clim;
    bit cbusy, s_start, s_ready, s_rst;
    logic [DW-1:0] s_arg;
    core_valid = 1'b0; core_done = 1'b0; core_output = '0;
    fa = 1; fb = 1; clim = 0; cbusy = 0;
    forever begin
      @(negedge clk);
      s_start = core_start; s_ready = core_ready; s_rst = core_reset; s_arg = core_arg;
      @(posedge clk); #1;
      if (s_rst) begin
        core_valid = 1'b0; core_done = 1'b0; cbusy = 0;
      end else if (s_start) begin
        core_valid = 1'b0; core_done = 1'b0; cbusy = !stub;
        clim = int'(s_arg); fa = 1; fb = 1;
      end else if (cbusy && !(core_valid && !s_ready)) begin
        if (core_done) begin
          if (s_ready) begin core_done = 1'b0; cbusy = 0; end
        end else if (fa >= clim) begin
          core_valid = 1'b0; core_done = 1'b1;
        end else if ($urandom_range(0, 4) == 0) begin
          core_valid = 1'b0;
        end else begin
          core_valid = fa[0]; core_output = DW'(fa);
          t = fa + fb; fa = fb; fb = t;
        end
      end
    end
  end

  // Monitor: grants, start latency, watchdog pulses and output beats, all checked on the falling edge.
  initial forever begin
    int g, c;
    beat_t e;
    @(negedge clk);
    if (!rst) begin
      if (req_ready != '0) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          c = (model_ptr + k) % N;
          if (g < 0 && req_valid[c]) g = c;
        end
        check("grant_onehot", longint'(req_ready), (g < 0) ? 0 : (longint'(1) << g));
        if (g >= 0) begin
          push_expected(g, int'(arg_tab[g]), stub);
          model_ptr = g;
          grant_log.push_back(g);
          gnt_arg = arg_tab[g];
        end
        grant_cyc = cyc;
        last_gap = cyc - last_acc_cyc;
        gnt_seen = req_ready;
      end
      if (core_start) begin
        check("start_latency", cyc - grant_cyc, 1);
        check("start_arg", longint'(core_arg), longint'(gnt_arg));
        start_cyc = cyc;
      end
      if (core_reset) begin
        wd_seen++;
        check("wd_only_on_stall", stub, 1);
        check("wd_timing", cyc - start_cyc, MI + 1);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL beat_unexpected: got id %0d data %0d last %0d, expected nothing", out_id, out_data, out_last);
        end else begin
          e = sbq.pop_front();
          check("beat_id", out_id, e.id);
          check("beat_data", longint'(out_data), e.data);
          check("beat_last", out_last, e.last);
          check("beat_err", out_err, e.err);
          if (out_last) last_acc_cyc = cyc;
          else begin beats_acc++; vals_in_run++; end
        end
      end
    end
  end

  task automatic issue(input int i, input int arg, input int q);
    quota[i] = q;
    arg_tab[i] = DW'(arg);
    req_arg[i*DW +: DW] = DW'(arg);
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (gnt_seen[i]) begin
        gnt_seen[i] = 1'b0;
        if (quota[i] > 0) quota[i]--;
        if (quota[i] == 0) req_valid[i] = 1'b0;
      end
    end
    case (ormode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (rand_req)
      for (int i = 0; i < N; i++)
        if (quota[i] == 0 && $urandom_range(0, 7) == 0) issue(i, int'($urandom_range(0, 150)), 1);
  endtask

  function automatic bit pending();
    bit p;
    p = (sbq.size() != 0);
    for (int i = 0; i < N; i++) if (quota[i] != 0) p = 1;
    return p;
  endfunction

  task automatic wait_idle(input string nm, input int limit);
    int n;
    n = 0;
    while (pending() && n < limit) begin step(); n++; end
    if (n >= limit) begin
      checks++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", nm, limit);
    end
    step(); step();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    sbq.delete();
    for (int i = 0; i < N; i++) quota[i] = 0;
    req_valid = '0;
    gnt_seen = '0;
    model_ptr = N - 1;
    step();
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_arg", longint'(core_arg), 0);
    check("rst_core_ready", core_ready, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_err", out_err, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp2[4];
    int b0, n;
    exp2 = '{0, 2, 0, 2};
    for (int i = 0; i < N; i++) begin quota[i] = 0; arg_tab[i] = '0; end
    ormode = 0;
    reset_dut();

    // Basic run: arg 10 yields 1,1,3,5 then the closing beat.
    vals_in_run = 0;
    issue(0, 10, 1);
    wait_idle("s1", 400);
    check("s1_value_beats", vals_in_run, 4);

    // Reset in the middle of the same run, then repeat it from scratch.
    b0 = beats_acc;
    issue(0, 10, 1);
    n = 0;
    while (beats_acc == b0 && n < 200) begin step(); n++; end
    check("s6_reached_run", (beats_acc > b0) ? 1 : 0, 1);
    reset_dut();
    vals_in_run = 0;
    issue(0, 10, 1);
    wait_idle("s6", 400);
    check("s6_value_beats", vals_in_run, 4);

    // Two requesters held together alternate 0,2,0,2.
    reset_dut();
    grant_log.delete();
    issue(0, 7, 2);
    issue(2, 30, 2);
    wait_idle("s2", 1000);
    check("s2_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("s2_grant_order", grant_log[i], exp2[i]);

    // Toggling backpressure; the watchdog must stay quiet.
    ormode = 1;
    wd_seen = 0;
    vals_in_run = 0;
    issue(1, 40, 1);
    wait_idle("s3", 800);
    check("s3_value_beats", vals_in_run, 6);
    check("s3_wd_silent", wd_seen, 0);

    // Empty run, then the next grant must follow the closing beat by one cycle.
    ormode = 0;
    issue(3, 0, 1);
    n = 0;
    while (quota[3] != 0 && n < 50) begin step(); n++; end
    issue(1, 10, 1);
    wait_idle("s4", 400);
    check("s4_next_grant_gap", last_gap, 1);

    // Silent core: watchdog resets it and closes the run with an error beat.
    stub = 1;
    wd_seen = 0;
    issue(2, 5, 1);
    wait_idle("s5", 200);
    check("s5_wd_pulses", wd_seen, 1);
    stub = 0;

    // Randomised traffic with random backpressure.
    ormode = 2;
    rand_req = 1;
    repeat (3000) step();
    rand_req = 0;
    wait_idle("random", 4000);
    check("random_sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
